// File: rtl/traffic_dp.sv
// Traffic-light datapath: per-state dwell counter, done decode, pedestrian
// request conditioning, lamp decode, round counter and illegal-state flag.
module traffic_dp #(
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned G_CYC    = 1024,
  parameter int unsigned NONE_CYC = 256,
  parameter int unsigned Y_CYC    = 512,
  parameter int unsigned R_CYC    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] curr_state,
  input  logic       dp_cnt_rst,
  input  logic       pass_req,
  output logic [6:0] done_state,
  output logic       pass,
  output logic       lamp_g,
  output logic       lamp_y,
  output logic       lamp_r,
  output logic [7:0] rounds,
  output logic       state_err
);

  localparam int unsigned S_G1    = 1;
  localparam int unsigned S_NONE1 = 2;
  localparam int unsigned S_G2    = 3;
  localparam int unsigned S_NONE2 = 4;
  localparam int unsigned S_G3    = 5;
  localparam int unsigned S_Y     = 6;
  localparam int unsigned S_R     = 7;

  // Terminal counts truncated to CNT_W: a dwell of 2^CNT_W ends at all-ones.
  localparam logic [CNT_W-1:0] G_END    = CNT_W'(G_CYC - 1);
  localparam logic [CNT_W-1:0] NONE_END = CNT_W'(NONE_CYC - 1);
  localparam logic [CNT_W-1:0] Y_END    = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] R_END    = CNT_W'(R_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [7:0]       rounds_q, rounds_d;
  logic             state_err_q, state_err_d;
  logic             one_hot;

  always_comb begin
    one_hot = $onehot(curr_state);

    done_state = '0;
    if (one_hot) begin
      done_state[0] = curr_state[S_G1]    & (cnt_q == G_END);
      done_state[1] = curr_state[S_NONE1] & (cnt_q == NONE_END);
      done_state[2] = curr_state[S_G2]    & (cnt_q == G_END);
      done_state[3] = curr_state[S_NONE2] & (cnt_q == NONE_END);
      done_state[4] = curr_state[S_G3]    & (cnt_q == G_END);
      done_state[5] = curr_state[S_Y]     & (cnt_q == Y_END);
      done_state[6] = curr_state[S_R]     & (cnt_q == R_END);
    end

    // Any non-one-hot encoding shows red only.
    lamp_g = 1'b0;
    lamp_y = 1'b0;
    lamp_r = 1'b1;
    if (one_hot) begin
      lamp_g = curr_state[S_G1] | curr_state[S_G2] | curr_state[S_G3];
      lamp_y = curr_state[S_Y];
      lamp_r = curr_state[S_R];
    end

    if (dp_cnt_rst)  cnt_d = '0;
    else if (&cnt_q) cnt_d = cnt_q;
    else             cnt_d = cnt_q + CNT_W'(1);

    s1_d = pass_req;
    s2_d = s1_q;
    s3_d = s2_q;

    rounds_d    = (curr_state[S_R] & done_state[6]) ? rounds_q + 8'd1 : rounds_q;
    state_err_d = state_err_q | ~one_hot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      rounds_q    <= '0;
      state_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      rounds_q    <= rounds_d;
      state_err_q <= state_err_d;
    end
  end

  assign pass      = s2_q & ~s3_q;
  assign rounds    = rounds_q;
  assign state_err = state_err_q;

endmodule
